// File: rtl/mul_div_ctrl.sv
// -----------------------------------------------------------------------------
// mul_div_ctrl
//
// Control sequencer for a single MUL or DIV operation on a register-file/ALU
// datapath. One accepted request walks the datapath through:
//   LOAD_Y -> (WAIT x ALU_WAIT) -> EXEC -> WR_LO -> WR_HI -> DONE -> IDLE
// An illegal opcode goes through ERR instead, with no datapath activity.
//
// Every output is decoded from the state register and the operands captured
// at acceptance. No input reaches an output combinationally.
//
// Parameters
//   ALU_WAIT  idle settle cycles (0..15) between LOAD_Y and EXEC
//
// Ports
//   Clock     system clock, rising edge active
//   clear     asynchronous active-low reset
//   start     request one operation (sampled only in IDLE)
//   opcode    5'b01010 = MUL, 5'b01011 = DIV, anything else is illegal
//   ra, rb    operand register indices (ra -> Y, rb -> bus in WAIT/EXEC)
//   busy      high whenever the sequencer is not idle
//   done      one-cycle completion pulse
//   illegal   one-cycle pulse for an accepted illegal opcode
//   Rout      one-hot register bus-drive enables
//   Yin       Y load strobe
//   Zhighin, Zlowin    Z capture strobes
//   Zhighout, Zlowout  Z bus-drive enables
//   HIin, LOin         HI / LO load strobes
//   alu_op    opcode presented to the ALU (0 when not operating)
// -----------------------------------------------------------------------------
module mul_div_ctrl #(
  parameter int unsigned ALU_WAIT = 0
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [15:0] Rout,
  output logic        Yin,
  output logic        Zhighin,
  output logic        Zlowin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  alu_op
);

  localparam logic [4:0] OP_MUL = 5'b01010;
  localparam logic [4:0] OP_DIV = 5'b01011;

  // The counter is preloaded in LOAD_Y with ALU_WAIT-1 so that WAIT lasts
  // exactly ALU_WAIT cycles; with ALU_WAIT=0 WAIT is skipped entirely.
  localparam logic [3:0] WAIT_LOAD = (ALU_WAIT == 0) ? 4'd0 : 4'(ALU_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_WAIT,
    S_EXEC,
    S_WR_LO,
    S_WR_HI,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] op_q;
  logic [3:0] ra_q, rb_q;
  logic [3:0] cnt_q;
  logic       op_legal;

  assign op_legal = (opcode == OP_MUL) || (opcode == OP_DIV);

  // NOTE: state-holding logic uses non-blocking (<=) so every flop samples
  // the values that were present before the edge.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the captured operands are ordinary control flops, so they are reset
  // along with the FSM; a cleared controller never exposes stale indices.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      op_q <= 5'd0;
      ra_q <= 4'd0;
      rb_q <= 4'd0;
    end else if (state_q == S_IDLE && start) begin
      op_q <= opcode;
      ra_q <= ra;
      rb_q <= rb;
    end
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      cnt_q <= 4'd0;
    end else if (state_q == S_LOAD_Y) begin
      cnt_q <= WAIT_LOAD;
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path through the block leaves a value unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    done     = 1'b0;
    illegal  = 1'b0;
    Rout     = 16'h0000;
    Yin      = 1'b0;
    Zhighin  = 1'b0;
    Zlowin   = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    alu_op   = 5'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = op_legal ? S_LOAD_Y : S_ERR;
        end
      end
      S_LOAD_Y: begin
        Rout    = 16'h0001 << ra_q;
        Yin     = 1'b1;
        alu_op  = op_q;
        state_d = (ALU_WAIT > 0) ? S_WAIT : S_EXEC;
      end
      S_WAIT: begin
        Rout   = 16'h0001 << rb_q;
        alu_op = op_q;
        if (cnt_q == 4'd0) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        Rout    = 16'h0001 << rb_q;
        Zhighin = 1'b1;
        Zlowin  = 1'b1;
        alu_op  = op_q;
        state_d = S_WR_LO;
      end
      S_WR_LO: begin
        Zlowout = 1'b1;
        LOin    = 1'b1;
        alu_op  = op_q;
        state_d = S_WR_HI;
      end
      S_WR_HI: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        alu_op   = op_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        illegal = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_div_ctrl
//
// Drives two controllers (ALU_WAIT = 0 and ALU_WAIT = 3) from the same
// stimulus and compares every cycle against a reference that describes each
// operation as "what the outputs look like k cycles after acceptance".
// -----------------------------------------------------------------------------
module tb_mul_div_ctrl;

  localparam int W0 = 0;
  localparam int W1 = 3;

  logic        Clock;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb;

  logic        busy0, done0, illegal0, yin0, zhin0, zlin0, zhout0, zlout0, hiin0, loin0;
  logic [15:0] rout0;
  logic [4:0]  aluop0;
  logic        busy1, done1, illegal1, yin1, zhin1, zlin1, zhout1, zlout1, hiin1, loin1;
  logic [15:0] rout1;
  logic [4:0]  aluop1;

  logic [30:0] obs0, obs1;
  assign obs0 = {busy0, done0, illegal0, rout0, yin0, zhin0, zlin0, zhout0, zlout0, hiin0, loin0, aluop0};
  assign obs1 = {busy1, done1, illegal1, rout1, yin1, zhin1, zlin1, zhout1, zlout1, hiin1, loin1, aluop1};

  mul_div_ctrl #(.ALU_WAIT(W0)) u_dut0 (
    .Clock(Clock), .clear(clear), .start(start), .opcode(opcode), .ra(ra), .rb(rb),
    .busy(busy0), .done(done0), .illegal(illegal0), .Rout(rout0), .Yin(yin0),
    .Zhighin(zhin0), .Zlowin(zlin0), .Zhighout(zhout0), .Zlowout(zlout0),
    .HIin(hiin0), .LOin(loin0), .alu_op(aluop0)
  );

  mul_div_ctrl #(.ALU_WAIT(W1)) u_dut1 (
    .Clock(Clock), .clear(clear), .start(start), .opcode(opcode), .ra(ra), .rb(rb),
    .busy(busy1), .done(done1), .illegal(illegal1), .Rout(rout1), .Yin(yin1),
    .Zhighin(zhin1), .Zlowin(zlin1), .Zhighout(zhout1), .Zlowout(zlout1),
    .HIin(hiin1), .LOin(loin1), .alu_op(aluop1)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit is_legal(input logic [4:0] op);
    return (op == 5'b01010) || (op == 5'b01011);
  endfunction

  // Index of the last busy cycle of an operation (DONE or ERR cycle).
  function automatic int last_cycle(input int w, input logic [4:0] op);
    return is_legal(op) ? (w + 5) : 1;
  endfunction

  // Expected output vector k cycles after the accepting edge (k=0: idle).
  function automatic logic [30:0] exp_at(input int w, input logic [4:0] op,
                                         input logic [3:0] a, input logic [3:0] b,
                                         input int k);
    logic        e_busy, e_done, e_ill, e_y, e_zhi, e_zli, e_zho, e_zlo, e_hi, e_lo;
    logic [15:0] e_r;
    logic [4:0]  e_alu;
    {e_busy, e_done, e_ill, e_y, e_zhi, e_zli, e_zho, e_zlo, e_hi, e_lo} = '0;
    e_r   = '0;
    e_alu = '0;
    if (k >= 1 && !is_legal(op)) begin
      if (k == 1) begin
        e_busy = 1'b1;
        e_ill  = 1'b1;
      end
    end else if (k >= 1 && k <= w + 5) begin
      e_busy = 1'b1;
      if (k <= w + 4) e_alu = op;
      if (k == 1) begin
        e_r = 16'h0001 << a;
        e_y = 1'b1;
      end else if (k <= w + 2) begin
        e_r = 16'h0001 << b;
        if (k == w + 2) begin
          e_zhi = 1'b1;
          e_zli = 1'b1;
        end
      end else if (k == w + 3) begin
        e_zlo = 1'b1;
        e_lo  = 1'b1;
      end else if (k == w + 4) begin
        e_zho = 1'b1;
        e_hi  = 1'b1;
      end else begin
        e_done = 1'b1;
      end
    end
    return {e_busy, e_done, e_ill, e_r, e_y, e_zhi, e_zli, e_zho, e_zlo, e_hi, e_lo, e_alu};
  endfunction

  function automatic int w_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  int         mk  [2];
  logic [4:0] mop [2];
  logic [3:0] ma  [2];
  logic [3:0] mb  [2];

  always @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int d = 0; d < 2; d++) begin
        mk[d]  <= 0;
        mop[d] <= '0;
        ma[d]  <= '0;
        mb[d]  <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mk[d] >= 1 && mk[d] <= last_cycle(w_of(d), mop[d])) begin
          mk[d] <= mk[d] + 1;
        end else if (start) begin
          mk[d]  <= 1;
          mop[d] <= opcode;
          ma[d]  <= ra;
          mb[d]  <= rb;
        end else begin
          mk[d] <= 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s @%0t: got %h expected %h", phase, tag, $time, obs, exp);
    end
  endtask

  // Drive inputs, compare both controllers mid-cycle, then advance to just
  // after the next rising edge.
  task automatic step(input logic s, input logic [4:0] op, input logic [3:0] a, input logic [3:0] b);
    start  = s;
    opcode = op;
    ra     = a;
    rb     = b;
    @(negedge Clock);
    check("w0", {1'b0, obs0}, {1'b0, exp_at(W0, mop[0], ma[0], mb[0], mk[0])});
    check("w3", {1'b0, obs1}, {1'b0, exp_at(W1, mop[1], ma[1], mb[1], mk[1])});
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [4:0] rand_legal();
    return 5'b01010 | 5'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] rand_op();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : rand_legal();
  endfunction

  task automatic step_noise(input logic s);
    step(s, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  initial begin
    bit found;
    start  = 1'b0;
    opcode = '0;
    ra     = '0;
    rb     = '0;
    clear  = 1'b1;
    #1 clear = 1'b0;
    repeat (3) step(1'b1, 5'b01010, 4'd3, 4'd4);

    // Basic MUL, ra=0, rb=2, then quiet until both controllers finish.
    phase = "mul_basic";
    clear = 1'b1;
    step(1'b1, 5'b01010, 4'd0, 4'd2);
    repeat (10) step(1'b0, 5'b00000, 4'd0, 4'd0);

    // DIV with ra == rb, operands scrambled every cycle after acceptance.
    phase = "div_same_reg";
    step(1'b1, 5'b01011, 4'd5, 4'd5);
    repeat (10) step_noise(1'b0);

    // Illegal opcode.
    phase = "illegal";
    step(1'b1, 5'b00111, 4'd1, 4'd9);
    repeat (4) step(1'b0, 5'b00000, 4'd0, 4'd0);

    // Boundary register indices.
    phase = "reg15";
    step(1'b1, 5'b01011, 4'd15, 4'd0);
    repeat (10) step_noise(1'b0);

    // Held start, back-to-back legal operations.
    phase = "held_start";
    repeat (60) step(1'b1, rand_legal(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    repeat (10) step(1'b0, 5'b00000, 4'd0, 4'd0);

    // Random traffic mixing legal and illegal requests.
    phase = "random";
    repeat (500) step($urandom_range(0, 1) == 1, rand_op(),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    repeat (10) step(1'b0, 5'b00000, 4'd0, 4'd0);

    // Asynchronous clear while the ALU_WAIT=3 controller is in EXEC.
    phase = "clear_exec";
    step(1'b1, 5'b01010, 4'd6, 4'd7);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mk[1] == W1 + 2) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 5'b00000, 4'd0, 4'd0);
    end
    if (!found) begin
      check("exec_reached", 32'd0, 32'd1);
    end else begin
      #1 clear = 1'b0;
      #1;
      check("async_w0", {1'b0, obs0}, 32'd0);
      check("async_w3", {1'b0, obs1}, 32'd0);
      @(posedge Clock);
      #1;
      repeat (2) step(1'b1, 5'b01011, 4'd2, 4'd3);
    end
    clear = 1'b1;
    step(1'b1, 5'b01011, 4'd8, 4'd1);
    repeat (12) step_noise(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_ctrl.md
MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

Interface
REQ-001 Parameter: ALU_WAIT, default 0, number of idle settle cycles (0..15) inserted before Z capture.
REQ-002 Clock  input  1  system clock; all state changes on its rising edge.
REQ-003 clear  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to run one MUL/DIV operation; sampled on rising edge.
REQ-005 opcode  input  5  operation code: 5'b01010 = MUL, 5'b01011 = DIV; all other values are illegal.
REQ-006 ra  input  4  index of first operand register (routed to Y).
REQ-007 rb  input  4  index of second operand register (driven on bus during execution).
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 done  output  1  one-cycle pulse on successful completion.
REQ-010 illegal  output  1  one-cycle pulse when an accepted request carries an illegal opcode.
REQ-011 Rout  output  16  one-hot register bus-drive enables (bit n drives Rn onto the bus).
REQ-012 Yin  output  1  Y register load strobe.
REQ-013 Zhighin, Zlowin  output  1 each  Z high and low capture strobes.
REQ-014 Zhighout, Zlowout  output  1 each  Z high and low bus-drive enables.
REQ-015 HIin, LOin  output  1 each  HI and LO register load strobes.
REQ-016 alu_op  output  5  operation code presented to the ALU.

Function
REQ-017 States: IDLE, LOAD_Y, WAIT, EXEC, WR_LO, WR_HI, DONE, ERR; encoding is free.
REQ-018 All outputs are registered or decoded only from the state register and captured operands; there is no combinational path from any input to any output.
REQ-019 IDLE: when start=1 on a rising edge, capture opcode, ra and rb into internal registers; go to LOAD_Y if the opcode is legal, otherwise go to ERR.
REQ-020 ERR: illegal=1 for one cycle, all strobes 0, then return to IDLE.
REQ-021 LOAD_Y: Rout[ra]=1 and Yin=1; alu_op equals the captured opcode; next state is WAIT if ALU_WAIT>0, otherwise EXEC.
REQ-022 WAIT: Rout[rb]=1, no strobes asserted; a 4-bit counter holds this state for exactly ALU_WAIT cycles, then the FSM goes to EXEC.
REQ-023 EXEC: Rout[rb]=1, Zhighin=1 and Zlowin=1 together for exactly one cycle; next state is WR_LO.
REQ-024 WR_LO: Zlowout=1 and LOin=1; next state is WR_HI.
REQ-025 WR_HI: Zhighout=1 and HIin=1; next state is DONE.
REQ-026 DONE: done=1 for one cycle, then return to IDLE.
REQ-027 alu_op holds the captured opcode from LOAD_Y through WR_HI inclusive and is 0 in all other states.
REQ-028 Latency: done is asserted exactly 5+ALU_WAIT cycles after the accepting edge.
REQ-029 Mutual exclusion: at most one of {Rout bits, Zhighout, Zlowout} is high in any cycle; in IDLE, ERR and DONE, Rout and all strobes are 0.
REQ-030 start is ignored while busy=1, including in DONE and ERR; a held start is accepted on the first edge in IDLE.
REQ-031 ra==rb is legal; the same Rout bit is driven in both LOAD_Y and EXEC.
REQ-032 Changes to opcode, ra or rb after acceptance have no effect on the operation in progress.

Reset
REQ-033 While clear=0: FSM is in IDLE, counter and captured registers are 0, and every output is 0 (Rout=16'h0000, alu_op=5'b00000); this applies immediately, including mid-operation.
REQ-034 After clear returns to 1, the first start can be accepted on the next rising edge.

Verification
REQ-035 ALU_WAIT=0, start with opcode=01010, ra=0, rb=2 -> Rout=0x0001+Yin; then Rout=0x0004+Zhighin+Zlowin; then Zlowout+LOin; then Zhighout+HIin; done high exactly 5 cycles after accept.
REQ-036 ALU_WAIT=3, opcode=01011, ra=5, rb=5 -> Rout=0x0020 for 5 consecutive cycles (Yin only in the first); Z strobes on the fifth of these cycles; done at cycle 8.
REQ-037 opcode=00111 with start -> illegal pulses once one cycle after accept; no Rout or strobe activity; busy returns low one cycle later.
REQ-038 start held high continuously with legal ops -> back-to-back operations, each accepted one cycle after the previous done; no start is accepted while busy=1.
REQ-039 clear=0 asserted during EXEC -> all outputs 0 without waiting for a clock edge; no done pulse; a new op after release completes normally.
REQ-040 Change opcode, ra and rb every cycle during a running operation -> the sequence uses only the values captured at accept.
